// File: rtl/swreg_commit_ctrl.sv
// OPB slave with staging/active software register pairs. A COMMIT write arms a
// one-cycle copy of every staging word into the active bank on the next user_sync.
module swreg_commit_ctrl #(
    parameter logic [31:0] C_BASEADDR   = 32'h01001200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010012FF,
    parameter int          C_NUM_REGS   = 4,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic                        Sl_xferAck,
    output logic [C_NUM_REGS*32-1:0]    user_data_out,
    output logic                        user_update,
    input  logic                        user_sync,
    output logic                        commit_pending
);
    typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;

    state_t                       state;
    logic [31:0]                  addr, wdata, offset, rdata;
    logic [3:0]                   be;
    logic                         hit, acc, wr, rd, ack_done;
    logic                         ctrl_wr, do_commit, do_abort, do_clr;
    logic [C_NUM_REGS-1:0][31:0]  stage, active;
    logic [15:0]                  commit_cnt;
    logic                         overrun;
    logic [2:0]                   active_sel;
    logic                         unused;

    // Big-endian OPB vectors land here with bit 0 as MSB, so be[i] covers wdata[8i+7:8i].
    assign addr   = OPB_ABus;
    assign wdata  = OPB_DBus;
    assign be     = OPB_BE;
    assign offset = addr - C_BASEADDR;
    assign unused = OPB_seqAddr;

    assign hit = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign acc = hit && !ack_done;
    assign wr  = acc && !OPB_RNW;
    assign rd  = acc && OPB_RNW;

    assign ctrl_wr   = wr && (offset == 32'h40);
    assign do_abort  = ctrl_wr && wdata[1];
    assign do_commit = ctrl_wr && wdata[0] && !wdata[1];
    assign do_clr    = ctrl_wr && wdata[2];

    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign user_data_out = active;

    always_comb begin
        rdata = '0;
        for (int k = 0; k < C_NUM_REGS; k++)
            if (offset == 32'(4 * k)) rdata = stage[k];
        if (offset == 32'h40) rdata = {commit_cnt, 14'd0, overrun, commit_pending};
        if (offset == 32'h44) rdata = {29'd0, active_sel};
        if (offset == 32'h48)
            for (int k = 0; k < C_NUM_REGS; k++)
                if (active_sel == 3'(k)) rdata = active[k];
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
            ack_done   <= 1'b0;
            active_sel <= '0;
        end else begin
            Sl_xferAck <= acc;
            Sl_DBus    <= rd ? rdata : '0;
            // One ack per select assertion; re-arm only once the master drops select.
            if (!OPB_select) ack_done <= 1'b0;
            else if (acc)    ack_done <= 1'b1;
            if (wr && offset == 32'h44) active_sel <= wdata[2:0];
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            stage <= '0;
        end else begin
            for (int k = 0; k < C_NUM_REGS; k++)
                for (int b = 0; b < 4; b++)
                    if (wr && offset == 32'(4 * k) && be[b])
                        stage[k][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state          <= IDLE;
            active         <= '0;
            commit_cnt     <= '0;
            overrun        <= 1'b0;
            user_update    <= 1'b0;
            commit_pending <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (do_clr) overrun <= 1'b0;
            case (state)
                IDLE: if (do_commit) begin
                    state          <= PEND;
                    commit_pending <= 1'b1;
                end
                PEND: if (do_abort) begin
                    state          <= IDLE;
                    commit_pending <= 1'b0;
                end else begin
                    if (do_commit) overrun <= 1'b1;
                    // Nonblocking copy: a STAGE write on this same edge stays staged.
                    if (user_sync) begin
                        state       <= APPLY;
                        active      <= stage;
                        user_update <= 1'b1;
                        commit_cnt  <= commit_cnt + 16'd1;
                    end
                end
                APPLY: begin
                    if (do_commit) overrun <= 1'b1;
                    state          <= IDLE;
                    commit_pending <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_swreg_commit_ctrl.sv
// Directed bench for swreg_commit_ctrl: table of register accesses, then
// hand-written commit/sync/abort/overrun/wrap/reset sequences.
module tb_swreg_commit_ctrl;
    localparam logic [31:0] BASE = 32'h01001200;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic [0:31]  abus = '0, dbus = '0;
    logic [0:3]   be = '0;
    logic         rnw = 1'b0, sel = 1'b0, seq = 1'b0, sync = 1'b0;
    logic [0:31]  sl_dbus;
    logic         err_ack, retry, tout_sup, xfer_ack, upd, pending;
    logic [127:0] udata;

    int checks = 0, errors = 0, upd_count = 0;

    swreg_commit_ctrl dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_errAck(err_ack), .Sl_retry(retry),
        .Sl_toutSup(tout_sup), .Sl_xferAck(xfer_ack), .user_data_out(udata),
        .user_update(upd), .user_sync(sync), .commit_pending(pending));

    always #5 clk = ~clk;
    always @(negedge clk) if (upd) upd_count++;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // One OPB transfer; ack must appear exactly one cycle after select is sampled.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       input logic r, input logic with_sync, input string nm,
                       output logic [31:0] rdat);
        @(negedge clk);
        abus = a; dbus = d; be = b; rnw = r; sel = 1'b1; sync = with_sync;
        @(posedge clk); #1;
        check({nm, " ack"}, xfer_ack, 1'b1);
        rdat = sl_dbus;
        sync = 1'b0;
        @(negedge clk);
        sel = 1'b0; rnw = 1'b0;
        @(posedge clk); #1;
        check({nm, " ack drop"}, {xfer_ack, sl_dbus}, 33'd0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input string nm);
        logic [31:0] dummy;
        bus(BASE + off, d, 4'hF, 1'b0, 1'b0, nm, dummy);
    endtask

    task automatic rd_chk(input logic [31:0] off, input logic [31:0] exp, input string nm);
        logic [31:0] v;
        bus(BASE + off, 32'h0, 4'hF, 1'b1, 1'b0, nm, v);
        check(nm, v, exp);
    endtask

    task automatic sync_pulse(output logic upd_at, output logic [127:0] data_at);
        @(negedge clk); sync = 1'b1;
        @(posedge clk); #1;
        upd_at = upd; data_at = udata;
        sync = 1'b0;
    endtask

    typedef struct {
        logic [31:0] off;
        logic [31:0] data;
        logic [3:0]  be;
        logic        rnw;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0]  v;
        logic         u;
        logic [127:0] ud;
        int           acks, base_upd;

        vecs[0]  = '{32'h00, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h0,        "w stage0 be0011"};
        vecs[1]  = '{32'h00, 32'h0,        4'b1111, 1'b1, 32'h0000BEEF, "r stage0"};
        vecs[2]  = '{32'h04, 32'h12345678, 4'b1100, 1'b0, 32'h0,        "w stage1 be1100"};
        vecs[3]  = '{32'h04, 32'h0,        4'b1111, 1'b1, 32'h12340000, "r stage1"};
        vecs[4]  = '{32'h08, 32'hA5A5A5A5, 4'b1111, 1'b0, 32'h0,        "w stage2"};
        vecs[5]  = '{32'h08, 32'h0,        4'b1111, 1'b1, 32'hA5A5A5A5, "r stage2"};
        vecs[6]  = '{32'h0C, 32'hCAFEF00D, 4'b0100, 1'b0, 32'h0,        "w stage3 be0100"};
        vecs[7]  = '{32'h0C, 32'h0,        4'b1111, 1'b1, 32'h00FE0000, "r stage3"};
        vecs[8]  = '{32'h44, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0,        "w active_sel"};
        vecs[9]  = '{32'h44, 32'h0,        4'b1111, 1'b1, 32'h00000007, "r active_sel"};
        vecs[10] = '{32'h48, 32'h0,        4'b1111, 1'b1, 32'h0,        "r active sel7"};
        vecs[11] = '{32'h80, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0,        "w unmapped"};
        vecs[12] = '{32'h10, 32'h0,        4'b1111, 1'b1, 32'h0,        "r unmapped stage4"};
        vecs[13] = '{32'h40, 32'h0,        4'b1111, 1'b1, 32'h0,        "r status idle"};

        #12;
        check("reset outputs", {xfer_ack, sl_dbus, upd, pending, udata, err_ack, retry, tout_sup}, '0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            bus(BASE + vecs[i].off, vecs[i].data, vecs[i].be, vecs[i].rnw, 1'b0, vecs[i].nm, v);
            if (vecs[i].rnw) check(vecs[i].nm, v, vecs[i].exp);
        end

        // Out-of-window address must never be acked.
        @(negedge clk);
        abus = 32'h01001300; rnw = 1'b1; sel = 1'b1; acks = 0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (xfer_ack) acks++; end
        check("miss no ack", acks, 0);
        // Held select: single ack only.
        @(negedge clk); abus = BASE + 32'h08; acks = 0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (xfer_ack) acks++; end
        check("held select one ack", acks, 1);
        @(negedge clk); sel = 1'b0; rnw = 1'b0;

        // Basic commit and apply
        wr(32'h00, 32'd1, "w s0"); wr(32'h04, 32'd2, "w s1");
        wr(32'h08, 32'd3, "w s2"); wr(32'h0C, 32'd4, "w s3");
        wr(32'h40, 32'h1, "commit");
        check("pending after commit", pending, 1'b1);
        rd_chk(32'h40, 32'h00000001, "status pending");
        repeat (10) @(posedge clk);
        #1 check("no early apply", udata, 128'd0);
        base_upd = upd_count;
        sync_pulse(u, ud);
        check("apply update", u, 1'b1);
        check("apply data", ud, {32'd4, 32'd3, 32'd2, 32'd1});
        @(posedge clk); #1;
        check("update one cycle", {upd, pending}, 2'b00);
        check("one update pulse", upd_count - base_upd, 1);
        rd_chk(32'h40, 32'h00010000, "status cnt1");
        wr(32'h44, 32'h2, "sel 2");
        rd_chk(32'h48, 32'd3, "active readback 2");

        // Overrun
        wr(32'h40, 32'h1, "commit a"); wr(32'h40, 32'h1, "commit b");
        rd_chk(32'h40, 32'h00010003, "status overrun");
        base_upd = upd_count;
        sync_pulse(u, ud);
        check("overrun apply", u, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("overrun single apply", upd_count - base_upd, 1);
        rd_chk(32'h40, 32'h00020002, "status overrun sticky");
        wr(32'h40, 32'h4, "clear overrun");
        rd_chk(32'h40, 32'h00020000, "status overrun cleared");

        // Abort
        wr(32'h00, 32'h99, "w s0 99");
        wr(32'h40, 32'h1, "commit"); wr(32'h40, 32'h2, "abort");
        check("abort clears pending", pending, 1'b0);
        base_upd = upd_count;
        sync_pulse(u, ud);
        repeat (2) @(posedge clk);
        #1 check("abort no update", upd_count - base_upd, 0);
        check("abort data kept", udata, {32'd4, 32'd3, 32'd2, 32'd1});
        wr(32'h40, 32'h3, "commit+abort idle");
        rd_chk(32'h40, 32'h00020000, "status after commit+abort");

        // Commit coincident with sync in IDLE, then STAGE write coincident with sync
        base_upd = upd_count;
        bus(BASE + 32'h40, 32'h1, 4'hF, 1'b0, 1'b1, "commit with sync", v);
        check("commit+sync pending only", {pending, upd}, 2'b10);
        bus(BASE + 32'h04, 32'h55, 4'hF, 1'b0, 1'b1, "stage1 on sync", v);
        check("sync-edge old stage applied", udata, {32'd4, 32'd3, 32'd2, 32'h99});
        check("sync-edge one update", upd_count - base_upd, 1);
        rd_chk(32'h04, 32'h55, "stage1 kept new");
        rd_chk(32'h40, 32'h00030000, "status cnt3");

        // Counter wrap
        @(negedge clk);
        force dut.commit_cnt = 16'hFFFF;
        #1 release dut.commit_cnt;
        rd_chk(32'h40, 32'hFFFF0000, "status cnt ffff");
        wr(32'h40, 32'h1, "commit wrap");
        sync_pulse(u, ud);
        repeat (2) @(posedge clk);
        rd_chk(32'h40, 32'h00000000, "status cnt wrap");

        // Reset mid-PEND
        wr(32'h40, 32'h1, "commit pre-reset");
        @(negedge clk); #2 rst_n = 1'b0;
        #1 check("reset mid-pend outputs", {xfer_ack, sl_dbus, upd, pending, udata}, '0);
        @(negedge clk); rst_n = 1'b1;
        base_upd = upd_count;
        sync_pulse(u, ud);
        repeat (2) @(posedge clk);
        #1 check("no apply after reset", upd_count - base_upd, 0);
        rd_chk(32'h00, 32'h0, "stage0 cleared");
        rd_chk(32'h44, 32'h0, "active_sel cleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/swreg_commit_ctrl.md
Name: swreg_commit_ctrl

Overview:
- OPB slave holding a bank of staging software registers, with a commit/apply sequencer.
- Software writes the staging words, then writes COMMIT.
- On the next user_sync pulse (frame/packet boundary from the chan_550_packet datapath), all staging words move to the active outputs in one cycle.
- Purpose: the channelizer/packetizer never sees a half-updated configuration set.

Parameters:
- C_BASEADDR, 32'h01001200: base of the slave window.
- C_HIGHADDR, 32'h010012FF: top of the slave window.
- C_NUM_REGS, 4: number of 32-bit staging/active register pairs (1..8).
- C_OPB_AWIDTH, 32: OPB address width.
- C_OPB_DWIDTH, 32: OPB data width.

Ports:
- OPB_Clk  in  1  single clock for bus and user side.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- OPB_ABus  in  [0:31]  OPB address.
- OPB_BE  in  [0:3]  byte enables; BE[0] maps to DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  transfer valid.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero unless acking a read.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1  constant 0.
- Sl_xferAck  out  1  transfer acknowledge.
- user_data_out  out  [C_NUM_REGS*32-1:0]  active registers; reg k occupies [32k+31:32k].
- user_update  out  1  one-cycle pulse, coincident with an active-register change.
- user_sync  in  1  boundary strobe from the datapath.
- commit_pending  out  1  high while a commit awaits user_sync.

Behaviour:
- Address map (offset = ABus - C_BASEADDR):
  - 0x00+4k: STAGE[k], R/W.
  - 0x40 CTRL (write): DBus[31] = commit, DBus[30] = abort.
  - 0x40 STATUS (read): [31] pending, [30] overrun sticky, [16:29] 0, [0:15] commit_cnt.
  - 0x44 ACTIVE_SEL (R/W, 3 bits): selects which active register reads back at 0x48.
  - 0x48: active readback, RO.
  - Unmapped offsets: read 0, writes dropped, still acked.
- Hit = OPB_select & address within [C_BASEADDR, C_HIGHADDR].
- OPB handshake:
  - Hit sampled at edge t; Sl_xferAck = 1 for exactly cycle t+1.
  - An ack_done flag blocks re-ack until OPB_select falls.
  - Write data is registered at that same edge, honouring BE per byte.
  - Read data is valid on Sl_DBus only while Sl_xferAck = 1.
- FSM states IDLE, PEND, APPLY:
  - IDLE: commit write -> PEND, commit_pending = 1.
  - PEND, user_sync = 1 at edge t:
    - At t+1: state APPLY, user_data_out = STAGE values as of edge t, user_update = 1.
    - At t+2: IDLE, user_update = 0, commit_pending = 0.
    - commit_cnt increments on the APPLY edge; wraps 0xFFFF -> 0x0000.
  - PEND, abort write -> IDLE; no copy, no count.
  - Abort in IDLE or APPLY: no effect.
- Boundary conditions:
  - Commit written while in PEND or APPLY: ignored; overrun sticky = 1. Overrun clears on a write to CTRL with DBus[29] = 1.
  - Commit and abort in the same write: abort wins; overrun unaffected.
  - STAGE writes during PEND: allowed; the value present at the sync edge is used.
  - STAGE write on the same edge as sync: the old STAGE value is applied and the new value stays staged.
  - user_sync in IDLE or APPLY: ignored.
  - Commit write and user_sync on the same edge in IDLE: go to PEND only; apply on a later sync.
- Reset (async assert, sync deassert in upstream fabric), all cleared:
  - Registers: STAGE, active, commit_cnt, overrun, ACTIVE_SEL = 0.
  - FSM: state = IDLE.
  - Outputs: Sl_xferAck, Sl_DBus, user_update, commit_pending = 0.
  - Reset mid-PEND discards the commit.

Test Plan:
1. Write STAGE0 = 0xDEADBEEF with BE = 4'b0011 over zero reset value -> read STAGE0 = 0x0000BEEF; each access acked exactly one cycle after select.
2. STAGE0..3 = 1,2,3,4; commit; user_sync 10 cycles later -> user_data_out = {4,3,2,1} one cycle after sync, user_update high one cycle, commit_cnt = 1, pending = 0.
3. Commit, then commit again before sync -> STATUS overrun = 1; one apply on sync; commit_cnt = 1; clear via DBus[29] -> overrun = 0.
4. Commit, abort, then user_sync -> user_data_out unchanged, commit_cnt = 0, no user_update.
5. Commit; on the sync edge write STAGE1 = 0x55 -> active reg1 = old value; STAGE1 reads 0x55.
6. Preload commit_cnt to 0xFFFF via 65535 commits (or force), then commit + sync -> commit_cnt = 0x0000. Assert OPB_Rst_n low mid-PEND -> all outputs 0, state IDLE.
